mips_reg_ctrl: RTL and testbench

MIPS_REG_CTRL -- requirements
Module: mips_reg_ctrl

---
 rtl/mips_reg_ctrl.sv | 117 +++++++++++
 tb/tb_mips_reg_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_reg_ctrl.sv
// mips_reg_ctrl: write-port controller for the MIPS register file.
// After reset (or an InitStart pulse) it sweeps INIT_VALUE into all 32
// registers. It then arbitrates two write requesters round-robin onto the
// single write port with one cycle of latency. Register 0 is never written
// by a requester.
module mips_reg_ctrl #(
   parameter logic [31:0] INIT_VALUE = 32'h0
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        InitStart,
   input  logic        Req0Valid,
   input  logic [4:0]  Req0Addr,
   input  logic [31:0] Req0Data,
   output logic        Req0Ready,
   input  logic        Req1Valid,
   input  logic [4:0]  Req1Addr,
   input  logic [31:0] Req1Data,
   output logic        Req1Ready,
   output logic        RegWrite,
   output logic [4:0]  WriteAddr,
   output logic [31:0] WriteData,
   output logic        Busy
);

   localparam logic ST_INIT = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   logic        state_q,       state_d;
   logic [4:0]  cnt_q,         cnt_d;
   logic        last_grant_q,  last_grant_d;
   logic        reg_write_q,   reg_write_d;
   logic [4:0]  write_addr_q,  write_addr_d;
   logic [31:0] write_data_q,  write_data_d;

   logic        can_grant;
   logic        grant0;
   logic        grant1;

   // Round-robin arbitration: a lone requester always wins. When both are
   // valid, the one that did not win last time gets the port. Nothing is
   // granted during a sweep or in the cycle that starts one.
   always_comb begin
      can_grant = (state_q == ST_RUN) && !InitStart;
      grant0    = can_grant && Req0Valid && (!Req1Valid || last_grant_q);
      grant1    = can_grant && Req1Valid && (!Req0Valid || !last_grant_q);
   end

   assign Req0Ready = grant0;
   assign Req1Ready = grant1;
   assign RegWrite  = reg_write_q;
   assign WriteAddr = write_addr_q;
   assign WriteData = write_data_q;
   assign Busy      = (state_q == ST_INIT);

   // Next-state logic: sweep addresses while in INIT, else forward the
   // granted write. The address and data hold when no write happens.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      reg_write_d  = 1'b0;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;

      case (state_q)
         ST_INIT: begin
            // InitStart is deliberately ignored here; the sweep runs to completion.
            reg_write_d  = 1'b1;
            write_addr_d = cnt_q;
            write_data_d = INIT_VALUE;
            cnt_d        = cnt_q + 5'd1;   // wraps to 0 after address 31
            if (cnt_q == 5'd31) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            if (InitStart) begin
               state_d = ST_INIT;
               cnt_d   = 5'd0;
            end else if (grant0) begin
               // Register 0 is hard-wired: accept the write but suppress it.
               reg_write_d  = (Req0Addr != 5'd0);
               write_addr_d = Req0Addr;
               write_data_d = Req0Data;
               last_grant_d = 1'b0;
            end else if (grant1) begin
               reg_write_d  = (Req1Addr != 5'd0);
               write_addr_d = Req1Addr;
               write_data_d = Req1Data;
               last_grant_d = 1'b1;
            end
         end
      endcase
   end

   // State registers. Reset aborts any sweep or pending write right away.
   // LastGrant resets to 1, so requester 0 wins the first contended cycle.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q      <= ST_INIT;
         cnt_q        <= 5'd0;
         last_grant_q <= 1'b1;
         reg_write_q  <= 1'b0;
         write_addr_q <= 5'd0;
         write_data_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         reg_write_q  <= reg_write_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
      end
   end

endmodule

// File: tb/tb_mips_reg_ctrl.sv
// Self-checking bench for mips_reg_ctrl: directed scenarios plus a randomized
// run checked against a transaction-level model of the write port.
module tb_mips_reg_ctrl;

   localparam logic [31:0] TB_INIT = 32'hDEAD_BEEF;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        InitStart;
   logic        Req0Valid, Req1Valid;
   logic [4:0]  Req0Addr,  Req1Addr;
   logic [31:0] Req0Data,  Req1Data;
   logic        Req0Ready, Req1Ready;
   logic        RegWrite;
   logic [4:0]  WriteAddr;
   logic [31:0] WriteData;
   logic        Busy;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit          m_busy;
   int          m_idx;
   int          m_last;
   bit          m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_grant;

   // Observations from the most recent step
   logic        o_r0, o_r1, o_we, o_busy;
   logic [4:0]  o_addr;
   logic [31:0] o_data;

   mips_reg_ctrl #(.INIT_VALUE(TB_INIT)) dut (
      .Clock(Clock), .Reset(Reset), .InitStart(InitStart),
      .Req0Valid(Req0Valid), .Req0Addr(Req0Addr), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
      .Req1Valid(Req1Valid), .Req1Addr(Req1Addr), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
      .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   // Which requester should win this cycle (-1 = none)
   function automatic int model_grant();
      if (m_busy || InitStart) return -1;
      if (Req0Valid && Req1Valid) return (m_last == 0) ? 1 : 0;
      if (Req0Valid) return 0;
      if (Req1Valid) return 1;
      return -1;
   endfunction

   function automatic void model_reset();
      m_busy = 1'b1; m_idx = 0; m_last = 1;
      m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
   endfunction

   // What the write port shows after a rising edge
   function automatic void model_edge(int g);
      if (m_busy) begin
         m_we = 1'b1; m_addr = 5'(m_idx); m_data = TB_INIT;
         if (m_idx == 31) begin m_busy = 1'b0; m_idx = 0; end
         else m_idx = m_idx + 1;
      end else if (InitStart) begin
         m_busy = 1'b1; m_idx = 0; m_we = 1'b0;
      end else if (g == 0) begin
         m_we = (Req0Addr != 5'd0); m_addr = Req0Addr; m_data = Req0Data; m_last = 0;
      end else if (g == 1) begin
         m_we = (Req1Addr != 5'd0); m_addr = Req1Addr; m_data = Req1Data; m_last = 1;
      end else begin
         m_we = 1'b0;
      end
   endfunction

   task automatic idle();
      InitStart = 1'b0;
      Req0Valid = 1'b0; Req0Addr = 5'd0; Req0Data = 32'd0;
      Req1Valid = 1'b0; Req1Addr = 5'd0; Req1Data = 32'd0;
   endtask

   // One clock: sample Ready before the edge, the write port after it.
   // Called at a falling edge with inputs already driven, returns at the next one.
   task automatic step();
      #1;
      m_grant = model_grant();
      o_r0 = Req0Ready; o_r1 = Req1Ready;
      @(posedge Clock);
      model_edge(m_grant);
      #1;
      o_we = RegWrite; o_addr = WriteAddr; o_data = WriteData; o_busy = Busy;
      @(negedge Clock);
   endtask

   task automatic test_reset();
      idle();
      Reset = 1'b0;
      Req0Valid = 1'b1; Req1Valid = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      n_checks++; if (RegWrite !== 1'b0)   begin n_errors++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite); end
      n_checks++; if (WriteAddr !== 5'd0)  begin n_errors++; $display("FAIL reset_addr: got %0d expected 0", WriteAddr); end
      n_checks++; if (WriteData !== 32'd0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", WriteData); end
      n_checks++; if (Busy !== 1'b1)       begin n_errors++; $display("FAIL reset_busy: got %b expected 1", Busy); end
      n_checks++; if (Req0Ready !== 1'b0 || Req1Ready !== 1'b0)
         begin n_errors++; $display("FAIL reset_ready: got %b%b expected 00", Req0Ready, Req1Ready); end
      model_reset();
      @(negedge Clock);
      idle();
      Reset = 1'b1;
      $display("test_reset: done");
   endtask

   task automatic test_init_sweep();
      for (int i = 0; i < 32; i++) begin
         step();
         n_checks++; if (o_we !== 1'b1 || o_addr !== 5'(i) || o_data !== TB_INIT)
            begin n_errors++; $display("FAIL sweep_write[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h", i, o_we, o_addr, o_data, i, TB_INIT); end
         n_checks++; if (o_busy !== (i != 31))
            begin n_errors++; $display("FAIL sweep_busy[%0d]: got %b expected %b", i, o_busy, (i != 31)); end
         n_checks++; if (o_r0 !== 1'b0 || o_r1 !== 1'b0)
            begin n_errors++; $display("FAIL sweep_ready[%0d]: got %b%b expected 00", i, o_r0, o_r1); end
      end
      step();
      n_checks++; if (o_we !== 1'b0 || o_busy !== 1'b0)
         begin n_errors++; $display("FAIL sweep_done: got we=%b busy=%b expected we=0 busy=0", o_we, o_busy); end
      $display("test_init_sweep: 32 init writes observed");
   endtask

   task automatic test_round_robin();
      int exp_g[4] = '{0, 1, 0, 1};
      logic [4:0] exp_a[4] = '{5'd1, 5'd2, 5'd1, 5'd2};
      logic [31:0] exp_d;
      int g;
      idle();
      Req0Valid = 1'b1; Req0Addr = 5'd1; Req0Data = 32'h1111_0001;
      Req1Valid = 1'b1; Req1Addr = 5'd2; Req1Data = 32'h2222_0002;
      for (int k = 0; k < 4; k++) begin
         step();
         g = o_r0 ? 0 : (o_r1 ? 1 : -1);
         exp_d = (exp_g[k] == 0) ? 32'h1111_0001 : 32'h2222_0002;
         n_checks++; if (o_r0 === 1'b1 && o_r1 === 1'b1)
            begin n_errors++; $display("FAIL rr_both_ready[%0d]: got 11 expected one-hot", k); end
         n_checks++; if (g != exp_g[k])
            begin n_errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", k, g, exp_g[k]); end
         n_checks++; if (o_we !== 1'b1 || o_addr !== exp_a[k] || o_data !== exp_d)
            begin n_errors++; $display("FAIL rr_write[%0d]: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h", k, o_we, o_addr, o_data, exp_a[k], exp_d); end
         $display("rr cycle %0d: grant=%0d addr=%0d data=%h", k, g, o_addr, o_data);
      end
      idle();
      step();
   endtask

   task automatic test_single();
      idle();
      Req0Valid = 1'b1; Req0Addr = 5'd5; Req0Data = 32'hA5A5_0005;
      step();
      n_checks++; if (o_r0 !== 1'b1 || o_r1 !== 1'b0)
         begin n_errors++; $display("FAIL single_ready: got %b%b expected 10", o_r0, o_r1); end
      n_checks++; if (o_we !== 1'b1 || o_addr !== 5'd5 || o_data !== 32'hA5A5_0005)
         begin n_errors++; $display("FAIL single_write: got we=%b addr=%0d data=%h expected we=1 addr=5 data=a5a50005", o_we, o_addr, o_data); end
      $display("single: req0 addr=%0d data=%h", o_addr, o_data);
      idle();
      step();
      n_checks++; if (o_we !== 1'b0 || o_addr !== 5'd5 || o_data !== 32'hA5A5_0005)
         begin n_errors++; $display("FAIL single_hold: got we=%b addr=%0d data=%h expected we=0 addr=5 data=a5a50005", o_we, o_addr, o_data); end
   endtask

   task automatic test_addr_zero();
      idle();
      Req1Valid = 1'b1; Req1Addr = 5'd0; Req1Data = 32'hFFFF_FFFF;
      step();
      n_checks++; if (o_r1 !== 1'b1)
         begin n_errors++; $display("FAIL zero_ready: got %b expected 1", o_r1); end
      n_checks++; if (o_we !== 1'b0)
         begin n_errors++; $display("FAIL zero_regwrite: got %b expected 0", o_we); end
      $display("addr_zero: req1 accepted, regwrite=%b", o_we);
      idle();
      step();
   endtask

   task automatic test_init_restart();
      idle();
      Req1Valid = 1'b1; Req1Addr = 5'd3; Req1Data = 32'h3333_0003;
      InitStart = 1'b1;
      step();
      n_checks++; if (o_r1 !== 1'b0 || o_we !== 1'b0 || o_busy !== 1'b1)
         begin n_errors++; $display("FAIL restart_start: got ready=%b we=%b busy=%b expected 0 0 1", o_r1, o_we, o_busy); end
      for (int i = 0; i < 32; i++) begin
         InitStart = (i == 10);   // must not restart the sweep
         step();
         n_checks++; if (o_r1 !== 1'b0)
            begin n_errors++; $display("FAIL restart_ready[%0d]: got %b expected 0", i, o_r1); end
         n_checks++; if (o_we !== 1'b1 || o_addr !== 5'(i))
            begin n_errors++; $display("FAIL restart_sweep[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", i, o_we, o_addr, i); end
      end
      InitStart = 1'b0;
      step();
      n_checks++; if (o_r1 !== 1'b1 || o_we !== 1'b1 || o_addr !== 5'd3 || o_data !== 32'h3333_0003)
         begin n_errors++; $display("FAIL restart_grant: got ready=%b we=%b addr=%0d data=%h expected 1 1 3 33330003", o_r1, o_we, o_addr, o_data); end
      $display("init_restart: held req1 granted addr=%0d", o_addr);
      idle();
      step();
   endtask

   task automatic test_reset_mid_sweep();
      idle();
      InitStart = 1'b1;
      step();
      InitStart = 1'b0;
      for (int i = 0; i < 17; i++) step();
      Req0Valid = 1'b1; Req0Addr = 5'd9; Req0Data = 32'h9;
      Reset = 1'b0;
      #1;
      n_checks++; if (RegWrite !== 1'b0 || WriteAddr !== 5'd0 || WriteData !== 32'd0)
         begin n_errors++; $display("FAIL midreset_outputs: got we=%b addr=%0d data=%h expected all 0", RegWrite, WriteAddr, WriteData); end
      n_checks++; if (Busy !== 1'b1 || Req0Ready !== 1'b0)
         begin n_errors++; $display("FAIL midreset_busy: got busy=%b ready0=%b expected 1 0", Busy, Req0Ready); end
      model_reset();
      @(negedge Clock);
      idle();
      Reset = 1'b1;
      step();
      n_checks++; if (o_we !== 1'b1 || o_addr !== 5'd0 || o_data !== TB_INIT)
         begin n_errors++; $display("FAIL midreset_restart: got we=%b addr=%0d data=%h expected we=1 addr=0 data=%h", o_we, o_addr, o_data, TB_INIT); end
      for (int i = 1; i < 32; i++) step();
      n_checks++; if (o_busy !== 1'b0 || o_addr !== 5'd31)
         begin n_errors++; $display("FAIL midreset_finish: got busy=%b addr=%0d expected 0 31", o_busy, o_addr); end
      $display("reset_mid_sweep: sweep restarted from 0");
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         InitStart = ($urandom_range(0, 59) == 0);
         Req0Valid = $urandom_range(0, 1); Req0Addr = 5'($urandom); Req0Data = $urandom;
         Req1Valid = $urandom_range(0, 1); Req1Addr = 5'($urandom); Req1Data = $urandom;
         step();
         n_checks++; if (o_r0 !== (m_grant == 0) || o_r1 !== (m_grant == 1))
            begin n_errors++; $display("FAIL rand_ready[%0d]: got %b%b expected grant %0d", k, o_r0, o_r1, m_grant); end
         n_checks++; if (o_we !== m_we || o_addr !== m_addr || o_data !== m_data)
            begin n_errors++; $display("FAIL rand_write[%0d]: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h", k, o_we, o_addr, o_data, m_we, m_addr, m_data); end
         n_checks++; if (o_busy !== m_busy)
            begin n_errors++; $display("FAIL rand_busy[%0d]: got %b expected %b", k, o_busy, m_busy); end
         if (m_grant >= 0)
            $display("rand %0d: grant=%0d addr=%0d data=%h we=%b", k, m_grant, o_addr, o_data, o_we);
      end
   endtask

   initial begin
      idle();
      Reset = 1'b0;
      model_reset();
      test_reset();
      test_init_sweep();
      test_round_robin();
      test_single();
      test_addr_zero();
      test_init_restart();
      test_reset_mid_sweep();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
